tfm_bus_sequencer: RTL and testbench

- Converts AY-style bus cycles (bdir/bc1) from the host into timed strobe sequences on the shared internal YM/SAA data bus.
- Tracks the chip-select/mode register (YM chip 0/1, SAA, read mode) and arbitrates the single internal bus between write and read requests.
- Sits between the AY pin decoder and the two YM2203 chips plus the SAA1099 on the TurboFMpro board; all timing is counted in fclk (28 MHz) cycles.

---
 rtl/tfm_pkg.sv | 46 ++++
 rtl/tfm_bus_sync.sv | 46 ++++
 rtl/tfm_bus_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_tfm_bus_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tfm_pkg.sv
// Shared encodings for the TurboFMpro bus sequencer.
// Optional fclk dividers in the top are enabled by defining TFM_CLKDIV_EN.
package tfm_pkg;

   typedef enum logic [1:0] {
      SEL_YM0 = 2'd0,
      SEL_YM1 = 2'd1,
      SEL_SAA = 2'd2
   } sel_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_SETUP,
      ST_W_STB,
      ST_W_HOLD,
      ST_R_STB,
      ST_R_HOLD
   } state_t;

   typedef enum logic [1:0] {
      REQ_AW,
      REQ_DW,
      REQ_RD
   } req_kind_t;

   localparam logic [7:0] CMD_SAA     = 8'hF7;
   localparam logic [7:0] CMD_YM_MASK = 8'hF8;

   typedef struct packed {
      req_kind_t  kind;
      sel_t       chip;
      logic       a0;
      logic [7:0] data;
   } bus_req_t;

   function automatic logic is_ym_cmd(input logic [7:0] v);
      return (v & CMD_YM_MASK) == CMD_YM_MASK;
   endfunction

   // The SAA1099 uses the opposite a0 polarity to the YM2203 for address/data.
   function automatic logic write_a0(input req_kind_t kind, input sel_t chip);
      if (chip == SEL_SAA) return kind == REQ_AW;
      return kind == REQ_DW;
   endfunction

endpackage

// File: rtl/tfm_bus_sync.sv
// Synchronises the asynchronous AY bdir/bc1 pins and turns their edges into
// single-cycle address-write, data-write and read request pulses.
module tfm_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic fclk,
   input  logic rst,
   input  logic bdir,
   input  logic bc1,
   output logic aw_pulse,
   output logic dw_pulse,
   output logic rd_pulse,
   output logic rd_level
);

   logic [SYNC_STAGES-1:0] bdir_sr;
   logic [SYNC_STAGES-1:0] bc1_sr;
   logic                   bdir_q;
   logic                   rd_q;
   logic                   bdir_s;
   logic                   bc1_s;

   assign bdir_s = bdir_sr[SYNC_STAGES-1];
   assign bc1_s  = bc1_sr[SYNC_STAGES-1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge fclk) begin
      if (rst) begin
         bdir_sr <= '0;
         bc1_sr  <= '0;
         bdir_q  <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         bdir_sr <= {bdir_sr[SYNC_STAGES-2:0], bdir};
         bc1_sr  <= {bc1_sr[SYNC_STAGES-2:0], bc1};
         bdir_q  <= bdir_s;
         rd_q    <= rd_level;
      end
   end

   assign rd_level = bc1_s & ~bdir_s;
   assign aw_pulse = bdir_s & ~bdir_q & bc1_s;
   assign dw_pulse = bdir_s & ~bdir_q & ~bc1_s;
   assign rd_pulse = rd_level & ~rd_q;

endmodule

// File: rtl/tfm_bus_sequencer.sv
// AY bus cycles to timed YM2203/SAA1099 strobe sequences on the shared bus.
// Define TFM_CLKDIV_EN to build the ymclk/saaclk dividers.
module tfm_bus_sequencer
   import tfm_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SETUP_CYC   = 2,
   parameter int STB_CYC     = 4,
   parameter int HOLD_CYC    = 2,
   parameter int RD_CYC      = 6
) (
   input  logic       fclk,
   input  logic       rst,
   input  logic       bdir,
   input  logic       bc1,
   input  logic [7:0] ayd_in,
   input  logic       mode_enable_saa,
   input  logic       mode_enable_ymfm,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   output logic       d_oe,
   output logic [7:0] rd_data,
   output logic       rd_oe,
   output logic       ymcs1_n,
   output logic       ymcs2_n,
   output logic       ymrd_n,
   output logic       ymwr_n,
   output logic       yma0,
   output logic       saacs_n,
   output logic       saawr_n,
   output logic       saaa0,
   output logic       busy,
   output logic       overrun,
   output logic       ymclk,
   output logic       saaclk
);

   logic     aw_pulse, dw_pulse, rd_pulse;
   state_t   state;
   logic [3:0] cnt;
   sel_t     sel;
   logic     rdmode;
   bus_req_t q;
   logic     q_valid;
   logic     cmd_hit;
   bus_req_t new_req;
   logic     new_valid;
   bus_req_t issue;

   tfm_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .fclk     (fclk),
      .rst      (rst),
      .bdir     (bdir),
      .bc1      (bc1),
      .aw_pulse (aw_pulse),
      .dw_pulse (dw_pulse),
      .rd_pulse (rd_pulse),
      .rd_level (rd_oe)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      cmd_hit   = aw_pulse && (is_ym_cmd(ayd_in) || ayd_in == CMD_SAA);
      new_req   = '{kind: REQ_DW, chip: sel, a0: 1'b0, data: ayd_in};
      new_valid = 1'b0;
      if (rd_pulse) begin
         new_req.kind = REQ_RD;
         new_req.a0   = rdmode;
         new_valid    = (sel != SEL_SAA);
      end else if (aw_pulse) begin
         new_req.kind = REQ_AW;
         new_req.a0   = write_a0(REQ_AW, sel);
         new_valid    = !cmd_hit;
      end else if (dw_pulse) begin
         new_req.a0   = write_a0(REQ_DW, sel);
         new_valid    = 1'b1;
      end
      issue = q_valid ? q : new_req;
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge fclk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         sel     <= SEL_YM0;
         rdmode  <= 1'b0;
         q       <= '{kind: REQ_DW, chip: SEL_YM0, a0: 1'b0, data: 8'h00};
         q_valid <= 1'b0;
         overrun <= 1'b0;
         rd_data <= 8'hFF;
         d_out   <= 8'h00;
         d_oe    <= 1'b0;
         ymcs1_n <= 1'b1;
         ymcs2_n <= 1'b1;
         ymrd_n  <= 1'b1;
         ymwr_n  <= 1'b1;
         yma0    <= 1'b0;
         saacs_n <= 1'b1;
         saawr_n <= 1'b1;
         saaa0   <= 1'b0;
      end else begin
         // Selection commands take effect at request time, even mid-sequence.
         if (cmd_hit) begin
            if (ayd_in == CMD_SAA) begin
               if (mode_enable_saa) sel <= SEL_SAA;
            end else begin
               sel    <= (ayd_in[0] && mode_enable_ymfm) ? SEL_YM1 : SEL_YM0;
               rdmode <= ayd_in[1] && mode_enable_ymfm;
            end
         end
         if (rd_pulse && sel == SEL_SAA) rd_data <= 8'hFF;

         // In IDLE a held entry is issued first and the new request takes its slot.
         if (state == ST_IDLE) begin
            if (q_valid) begin
               q       <= new_req;
               q_valid <= new_valid;
            end
         end else if (new_valid) begin
            if (!q_valid) begin
               q       <= new_req;
               q_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (q_valid || new_valid) begin
                  ymcs1_n <= (issue.chip != SEL_YM0);
                  ymcs2_n <= (issue.chip != SEL_YM1);
                  saacs_n <= (issue.chip != SEL_SAA);
                  if (issue.chip == SEL_SAA) saaa0 <= issue.a0;
                  else                       yma0  <= issue.a0;
                  if (issue.kind == REQ_RD) begin
                     state  <= ST_R_STB;
                     cnt    <= 4'(RD_CYC - 1);
                     ymrd_n <= 1'b0;
                     d_oe   <= 1'b0;
                  end else begin
                     state  <= ST_W_SETUP;
                     cnt    <= 4'(SETUP_CYC - 1);
                     d_out  <= issue.data;
                     d_oe   <= 1'b1;
                  end
               end
            end
            ST_W_SETUP: begin
               if (cnt == 4'd0) begin
                  state <= ST_W_STB;
                  cnt   <= 4'(STB_CYC - 1);
                  if (saacs_n == 1'b0) saawr_n <= 1'b0;
                  else                 ymwr_n  <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_W_STB: begin
               if (cnt == 4'd0) begin
                  state   <= ST_W_HOLD;
                  cnt     <= 4'(HOLD_CYC - 1);
                  ymwr_n  <= 1'b1;
                  saawr_n <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_W_HOLD: begin
               if (cnt == 4'd0) begin
                  state   <= ST_IDLE;
                  ymcs1_n <= 1'b1;
                  ymcs2_n <= 1'b1;
                  saacs_n <= 1'b1;
                  d_oe    <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_R_STB: begin
               if (cnt == 4'd0) begin
                  state   <= ST_R_HOLD;
                  cnt     <= 4'(HOLD_CYC - 1);
                  rd_data <= d_in;
                  ymrd_n  <= 1'b1;
                  ymcs1_n <= 1'b1;
                  ymcs2_n <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_R_HOLD: begin
               if (cnt == 4'd0) state <= ST_IDLE;
               else             cnt   <= cnt - 4'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef TFM_CLKDIV_EN
   logic [2:0] div_cnt;

   always_ff @(posedge fclk) begin
      if (rst) div_cnt <= '0;
      else     div_cnt <= div_cnt + 3'd1;
   end

   assign ymclk  = div_cnt[2];
   assign saaclk = div_cnt[1];
`else
   assign ymclk  = 1'b0;
   assign saaclk = 1'b0;
`endif

endmodule

// File: tb/tb_tfm_bus_sequencer.sv
// Directed bench for tfm_bus_sequencer: bus monitor records each strobe and
// the directed sequences compare against hand-computed chip/a0/data/timing.
module tb_tfm_bus_sequencer;

   logic       fclk = 1'b0;
   logic       rst = 1'b1;
   logic       bdir = 1'b0;
   logic       bc1 = 1'b0;
   logic [7:0] ayd_in = 8'h00;
   logic       mode_enable_saa = 1'b0;
   logic       mode_enable_ymfm = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic [7:0] d_out, rd_data;
   logic       d_oe, rd_oe;
   logic       ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0;
   logic       saacs_n, saawr_n, saaa0;
   logic       busy, overrun, ymclk, saaclk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit         is_rd;
      int         chip;
      logic       a0;
      logic [7:0] data;
      logic       oe;
      int         width;
   } ev_t;

   ev_t  evq[$];
   logic p_ywr = 1'b1, p_swr = 1'b1, p_yrd = 1'b1;
   int   low_cnt = 0, cs_cnt = 0, last_cs_width = 0;
   bit   cs2_seen = 0, ym_seen = 0;

   tfm_bus_sequencer dut (
      .fclk             (fclk),
      .rst              (rst),
      .bdir             (bdir),
      .bc1              (bc1),
      .ayd_in           (ayd_in),
      .mode_enable_saa  (mode_enable_saa),
      .mode_enable_ymfm (mode_enable_ymfm),
      .d_in             (d_in),
      .d_out            (d_out),
      .d_oe             (d_oe),
      .rd_data          (rd_data),
      .rd_oe            (rd_oe),
      .ymcs1_n          (ymcs1_n),
      .ymcs2_n          (ymcs2_n),
      .ymrd_n           (ymrd_n),
      .ymwr_n           (ymwr_n),
      .yma0             (yma0),
      .saacs_n          (saacs_n),
      .saawr_n          (saawr_n),
      .saaa0            (saaa0),
      .busy             (busy),
      .overrun          (overrun),
      .ymclk            (ymclk),
      .saaclk           (saaclk)
   );

   always #5 fclk = ~fclk;

   function automatic int cur_chip();
      if (!ymcs1_n) return 0;
      if (!ymcs2_n) return 1;
      if (!saacs_n) return 2;
      return 3;
   endfunction

   // Bus monitor: one event per strobe fall, low width filled in on the rise.
   always @(negedge fclk) begin
      if (!rst) begin
         if (p_ywr && !ymwr_n)  evq.push_back('{0, cur_chip(), yma0, d_out, d_oe, 0});
         if (p_swr && !saawr_n) evq.push_back('{0, cur_chip(), saaa0, d_out, d_oe, 0});
         if (p_yrd && !ymrd_n)  evq.push_back('{1, cur_chip(), yma0, 8'h00, d_oe, 0});
         if (!ymwr_n || !saawr_n || !ymrd_n) low_cnt++;
         else if (low_cnt != 0) begin
            if (evq.size() > 0) evq[evq.size()-1].width = low_cnt;
            low_cnt = 0;
         end
         if (!ymcs1_n || !ymcs2_n || !saacs_n) cs_cnt++;
         else if (cs_cnt != 0) begin
            last_cs_width = cs_cnt;
            cs_cnt = 0;
         end
         if (!ymcs2_n) cs2_seen = 1;
         if (!ymcs1_n || !ymcs2_n) ym_seen = 1;
      end
      p_ywr = ymwr_n;
      p_swr = saawr_n;
      p_yrd = ymrd_n;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic ev_t get_ev(input int i);
      ev_t none = '{0, -1, 1'bx, 8'hxx, 1'bx, -1};
      if (i < evq.size()) return evq[i];
      return none;
   endfunction

   task automatic settle();
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < 300) begin
         @(negedge fclk);
         n++;
         if (busy === 1'b0) quiet++;
         else               quiet = 0;
      end
      if (quiet < 4) check("settle_timeout", busy, 0);
   endtask

   task automatic ay_write(input logic aw, input logic [7:0] d);
      @(negedge fclk);
      bdir = 1'b1; bc1 = aw; ayd_in = d;
      repeat (4) @(negedge fclk);
      bdir = 1'b0; bc1 = 1'b0;
      repeat (3) @(negedge fclk);
      settle();
   endtask

   task automatic ay_read(input logic [7:0] v);
      @(negedge fclk);
      d_in = v; bdir = 1'b0; bc1 = 1'b1;
      repeat (12) @(negedge fclk);
      bc1 = 1'b0;
      repeat (3) @(negedge fclk);
      settle();
   endtask

   task automatic check_wr(input string tag, input int i, input int chip, input logic a0,
                           input logic [7:0] data);
      ev_t e = get_ev(i);
      check({tag, "_chip"}, e.chip, chip);
      check({tag, "_a0"}, {31'd0, e.a0}, {31'd0, a0});
      check({tag, "_data"}, {24'd0, e.data}, {24'd0, data});
   endtask

   initial begin
      int   lat;
      ev_t  e;

      // Reset state
      repeat (3) @(negedge fclk);
      rst = 1'b0;
      @(negedge fclk);
      check("rst_strobes", {ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, saacs_n, saawr_n}, 6'b111111);
      check("rst_a0", {yma0, saaa0}, 2'b00);
      check("rst_d", {d_oe, d_out}, 9'h000);
      check("rst_rd", {rd_oe, rd_data}, 9'h0FF);
      check("rst_flags", {busy, overrun}, 2'b00);

      // YM0 address then data write, with latency measured from bdir rising
      evq.delete(); cs2_seen = 0;
      @(negedge fclk);
      bdir = 1'b1; bc1 = 1'b1; ayd_in = 8'h3A;
      lat = 0;
      while (ymwr_n !== 1'b0 && lat < 50) begin
         @(posedge fclk);
         lat++;
         @(negedge fclk);
      end
      check("wr_latency", lat, 5);
      bdir = 1'b0; bc1 = 1'b0;
      settle();
      check("ym0_cs_width", last_cs_width, 8);
      ay_write(1'b0, 8'h5C);
      check("ym0_nev", evq.size(), 2);
      check_wr("ym0_aw", 0, 0, 1'b0, 8'h3A);
      check_wr("ym0_dw", 1, 0, 1'b1, 8'h5C);
      e = get_ev(0);
      check("ym0_aw_width", e.width, 4);
      check("ym0_aw_oe", {31'd0, e.oe}, 1);
      e = get_ev(1);
      check("ym0_dw_width", e.width, 4);
      check("ym0_cs2_idle", cs2_seen, 0);

      // SAA selection and SAA a0 polarity
      mode_enable_saa = 1'b1;
      evq.delete(); ym_seen = 0;
      ay_write(1'b1, 8'hF7);
      ay_write(1'b1, 8'h12);
      ay_write(1'b0, 8'h34);
      check("saa_nev", evq.size(), 2);
      check_wr("saa_aw", 0, 2, 1'b1, 8'h12);
      check_wr("saa_dw", 1, 2, 1'b0, 8'h34);
      check("saa_no_ym", ym_seen, 0);

      // F7 ignored with SAA disabled: writes stay on YM0
      mode_enable_saa = 1'b0;
      ay_write(1'b1, 8'hF8);
      evq.delete();
      ay_write(1'b1, 8'hF7);
      ay_write(1'b1, 8'h12);
      ay_write(1'b0, 8'h34);
      check("nosaa_nev", evq.size(), 2);
      check_wr("nosaa_aw", 0, 0, 1'b0, 8'h12);
      check_wr("nosaa_dw", 1, 0, 1'b1, 8'h34);

      // YM1 data-mode read
      mode_enable_ymfm = 1'b1;
      ay_write(1'b1, 8'hFF);
      evq.delete();
      @(negedge fclk);
      d_in = 8'hA5; bdir = 1'b0; bc1 = 1'b1;
      repeat (4) @(negedge fclk);
      check("rd_prev_data", rd_data, 8'hFF);
      check("rd_oe_on", rd_oe, 1);
      repeat (8) @(negedge fclk);
      bc1 = 1'b0;
      repeat (3) @(negedge fclk);
      check("rd_oe_off", rd_oe, 0);
      settle();
      e = get_ev(0);
      check("rd1_nev", evq.size(), 1);
      check("rd1_kind_chip", {e.is_rd, e.chip[1:0]}, 3'b101);
      check("rd1_a0", {31'd0, e.a0}, 1);
      check("rd1_width", e.width, 6);
      check("rd1_cs_width", last_cs_width, 6);
      check("rd1_data", rd_data, 8'hA5);

      // YM1 status read
      ay_write(1'b1, 8'hFD);
      evq.delete();
      ay_read(8'h3C);
      e = get_ev(0);
      check("rd2_chip_a0", {e.chip[1:0], e.a0}, 3'b010);
      check("rd2_data", rd_data, 8'h3C);

      // YM1 and data mode both forced off without ymfm enable
      mode_enable_ymfm = 1'b0;
      ay_write(1'b1, 8'hFF);
      evq.delete();
      ay_read(8'h5A);
      e = get_ev(0);
      check("rd3_chip_a0", {e.chip[1:0], e.a0}, 3'b000);
      check("rd3_data", rd_data, 8'h5A);

      // Read with SAA selected: no bus cycle, FF returned
      mode_enable_saa = 1'b1;
      ay_write(1'b1, 8'hF7);
      evq.delete();
      ay_read(8'h00);
      check("rd_saa_nev", evq.size(), 0);
      check("rd_saa_data", rd_data, 8'hFF);

      // Three writes inside one sequence: third dropped
      ay_write(1'b1, 8'hFC);
      evq.delete();
      check("ovr_before", overrun, 0);
      @(negedge fclk);
      bdir = 1'b1; bc1 = 1'b0; ayd_in = 8'h21;
      repeat (2) @(negedge fclk); bdir = 1'b0;
      @(negedge fclk); bdir = 1'b1; ayd_in = 8'h22;
      repeat (2) @(negedge fclk); bdir = 1'b0;
      @(negedge fclk); bdir = 1'b1; ayd_in = 8'h23;
      repeat (2) @(negedge fclk); bdir = 1'b0;
      repeat (2) @(negedge fclk);
      settle();
      check("ovr_nev", evq.size(), 2);
      check_wr("ovr_w1", 0, 0, 1'b1, 8'h21);
      check_wr("ovr_w2", 1, 0, 1'b1, 8'h22);
      check("ovr_flag", overrun, 1);

      // Reset during W_STB with a queued write
      @(negedge fclk);
      bdir = 1'b1; bc1 = 1'b0; ayd_in = 8'h77;
      repeat (2) @(negedge fclk); bdir = 1'b0;
      @(negedge fclk); bdir = 1'b1; ayd_in = 8'h78;
      repeat (2) @(negedge fclk); bdir = 1'b0;
      lat = 0;
      while (ymwr_n !== 1'b0 && lat < 50) begin
         @(negedge fclk);
         lat++;
      end
      check("rst_mid_stb_reached", ymwr_n, 0);
      @(negedge fclk);
      rst = 1'b1;
      @(negedge fclk);
      rst = 1'b0;
      evq.delete();
      check("rstm_strobes", {ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, saacs_n, saawr_n}, 6'b111111);
      check("rstm_d", {d_oe, d_out}, 9'h000);
      check("rstm_flags", {busy, overrun}, 2'b00);
      check("rstm_rd", rd_data, 8'hFF);
      check("rstm_clk", {ymclk, saaclk}, 2'b00);
      repeat (20) @(negedge fclk);
      check("rstm_queue_empty", evq.size(), 0);
      check("rstm_idle", busy, 0);

`ifdef TFM_CLKDIV_EN
      begin
         logic py = ymclk, ps = saaclk;
         int   yr0 = -1, yr1 = -1, sr0 = -1, sr1 = -1, yh = 0, sh = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge fclk);
            if (ymclk && !py) begin
               if (yr0 < 0) yr0 = i; else if (yr1 < 0) yr1 = i;
            end
            if (saaclk && !ps) begin
               if (sr0 < 0) sr0 = i; else if (sr1 < 0) sr1 = i;
            end
            if (yr0 >= 0 && yr1 < 0 && ymclk) yh++;
            if (sr0 >= 0 && sr1 < 0 && saaclk) sh++;
            py = ymclk;
            ps = saaclk;
         end
         check("ymclk_period", yr1 - yr0, 8);
         check("ymclk_high", yh, 4);
         check("saaclk_period", sr1 - sr0, 4);
         check("saaclk_high", sh, 2);
      end
`else
      begin
         int ones = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge fclk);
            if (ymclk !== 1'b0 || saaclk !== 1'b0) ones++;
         end
         check("clk_off", ones, 0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
